// File: rtl/sample_block_averager_if.sv
// rtl/sample_block_averager_if.sv - sample/averaged-sample bundle between a sample source and the block averager
//
// Signals:
//   data_i        packed unsigned samples, channel k = [k*WIDTH +: WIDTH]
//   data_valid_i  one-cycle pulse, data_i valid
//   flush_i       discard the partial block and restart counting
//   data_o        packed averaged samples, held between updates
//   data_valid_o  one-cycle pulse, new data_o
//   fill_o        samples accumulated in the current block
// Modports: master drives the samples and receives averages; slave is the averager.
interface sample_block_averager_if #(
    parameter int WIDTH        = 12,
    parameter int NUM_CHANNELS = 2,
    parameter int LOG2_N       = 2
);
    logic [NUM_CHANNELS*WIDTH-1:0] data_i;
    logic                          data_valid_i;
    logic                          flush_i;
    logic [NUM_CHANNELS*WIDTH-1:0] data_o;
    logic                          data_valid_o;
    logic [LOG2_N:0]               fill_o;

    modport master (
        output data_i, data_valid_i, flush_i,
        input  data_o, data_valid_o, fill_o
    );

    modport slave (
        input  data_i, data_valid_i, flush_i,
        output data_o, data_valid_o, fill_o
    );
endinterface

// File: rtl/sample_block_averager.sv
// rtl/sample_block_averager.sv - multi-channel block-averaging decimator
//
// Sums 2**LOG2_N consecutive valid samples per channel and emits one averaged
// packed word per block (truncated, or rounded half up when ROUND=1).
// Ports:
//   clk_i   in  system clock
//   rst_i   in  synchronous, active-high reset
//   bus     slave modport of sample_block_averager_if (samples in, averages out,
//           flush request, fill level)
module sample_block_averager #(
    parameter int WIDTH        = 12,
    parameter int NUM_CHANNELS = 2,
    parameter int LOG2_N       = 2,
    parameter int ROUND        = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    sample_block_averager_if.slave bus
);
    localparam int N     = 1 << LOG2_N;
    localparam int ACC_W = WIDTH + LOG2_N;
    // One spare bit so the rounding increment can never wrap the sum.
    localparam int SUM_W = ACC_W + 1;
    localparam int RND_I = (ROUND != 0 && LOG2_N > 0) ? (1 << ((LOG2_N > 0) ? LOG2_N - 1 : 0)) : 0;

    localparam logic [LOG2_N:0]  CNT_LAST = (LOG2_N + 1)'(N - 1);
    localparam logic [SUM_W-1:0] SAT      = SUM_W'((1 << WIDTH) - 1);

    logic [ACC_W-1:0]              acc [NUM_CHANNELS];
    logic [LOG2_N:0]               cnt;
    logic [NUM_CHANNELS*WIDTH-1:0] data_q;
    logic                          valid_q;

    logic [SUM_W-1:0]              sum_c [NUM_CHANNELS];
    logic [SUM_W-1:0]              shr_c [NUM_CHANNELS];
    logic [NUM_CHANNELS*WIDTH-1:0] avg_c;

    // Average of the block as it would be if the current sample completes it.
    always_comb begin
        avg_c = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            sum_c[k] = SUM_W'(acc[k]) + SUM_W'(bus.data_i[k*WIDTH +: WIDTH]) + SUM_W'(RND_I);
            shr_c[k] = sum_c[k] >> LOG2_N;
            avg_c[k*WIDTH +: WIDTH] = (shr_c[k] > SAT) ? SAT[WIDTH-1:0] : shr_c[k][WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            for (int k = 0; k < NUM_CHANNELS; k++) acc[k] <= '0;
        end else begin
            valid_q <= 1'b0;
            if (bus.flush_i) begin
                // Flush beats a coincident valid: that sample is dropped.
                cnt <= '0;
                for (int k = 0; k < NUM_CHANNELS; k++) acc[k] <= '0;
            end else if (bus.data_valid_i) begin
                if (cnt == CNT_LAST) begin
                    data_q  <= avg_c;
                    valid_q <= 1'b1;
                    cnt     <= '0;
                    for (int k = 0; k < NUM_CHANNELS; k++) acc[k] <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                    for (int k = 0; k < NUM_CHANNELS; k++)
                        acc[k] <= acc[k] + ACC_W'(bus.data_i[k*WIDTH +: WIDTH]);
                end
            end
        end
    end

    assign bus.data_o       = data_q;
    assign bus.data_valid_o = valid_q;
    assign bus.fill_o       = cnt;
endmodule

// File: tb/tb_sample_block_averager.sv
// tb/tb_sample_block_averager.sv - scoreboard bench for sample_block_averager
module tb_sample_block_averager;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] din = '0;
    logic        vin = 1'b0;
    logic        fin = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sample_block_averager_if #(.WIDTH(12), .NUM_CHANNELS(2), .LOG2_N(2)) if_def ();
    sample_block_averager_if #(.WIDTH(12), .NUM_CHANNELS(2), .LOG2_N(2)) if_rnd ();
    sample_block_averager_if #(.WIDTH(12), .NUM_CHANNELS(2), .LOG2_N(0)) if_pt ();

    assign if_def.data_i = din;  assign if_def.data_valid_i = vin;  assign if_def.flush_i = fin;
    assign if_rnd.data_i = din;  assign if_rnd.data_valid_i = vin;  assign if_rnd.flush_i = fin;
    assign if_pt.data_i  = din;  assign if_pt.data_valid_i  = vin;  assign if_pt.flush_i  = fin;

    sample_block_averager #(.WIDTH(12), .NUM_CHANNELS(2), .LOG2_N(2), .ROUND(0)) u_def (
        .clk_i(clk), .rst_i(rst), .bus(if_def.slave));
    sample_block_averager #(.WIDTH(12), .NUM_CHANNELS(2), .LOG2_N(2), .ROUND(1)) u_rnd (
        .clk_i(clk), .rst_i(rst), .bus(if_rnd.slave));
    sample_block_averager #(.WIDTH(12), .NUM_CHANNELS(2), .LOG2_N(0), .ROUND(1)) u_pt (
        .clk_i(clk), .rst_i(rst), .bus(if_pt.slave));

    typedef struct {
        logic [23:0] data;
        int          cyc;
    } exp_t;

    exp_t q_def[$];
    exp_t q_rnd[$];
    exp_t q_pt[$];

    // Model: index 0 = truncating N=4, 1 = rounding N=4, 2 = pass-through.
    int m_acc [3][2];
    int m_cnt [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_acc[i][0] = 0;
            m_acc[i][1] = 0;
        end
    endtask

    task automatic model_sample(input int c0, input int c1);
        int   smp [2];
        int   l2, n, s, a;
        exp_t e;
        smp[0] = c0;
        smp[1] = c1;
        for (int i = 0; i < 3; i++) begin
            l2 = (i == 2) ? 0 : 2;
            n  = 1 << l2;
            if (m_cnt[i] == n - 1) begin
                for (int ch = 0; ch < 2; ch++) begin
                    s = m_acc[i][ch] + smp[ch] + ((i == 1) ? n / 2 : 0);
                    a = s >> l2;
                    if (a > 4095) a = 4095;
                    e.data[ch*12 +: 12] = a[11:0];
                    m_acc[i][ch] = 0;
                end
                e.cyc = cyc + 1;
                m_cnt[i] = 0;
                if (i == 0) q_def.push_back(e);
                else if (i == 1) q_rnd.push_back(e);
                else q_pt.push_back(e);
            end else begin
                m_acc[i][0] += smp[0];
                m_acc[i][1] += smp[1];
                m_cnt[i]++;
            end
        end
    endtask

    // One cycle of stimulus; consecutive calls give back-to-back valids.
    task automatic drive(input int c0, input int c1, input bit v, input bit f);
        logic [11:0] a0, a1;
        @(posedge clk);
        #1;
        a0  = c0[11:0];
        a1  = c1[11:0];
        din = {a1, a0};
        vin = v;
        fin = f;
        if (f) model_clear();
        else if (v) model_sample(c0, c1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (if_def.data_valid_o === 1'b1) begin
            if (q_def.size() == 0) check("def_unexpected_pulse", 1, 0);
            else begin
                e = q_def.pop_front();
                check("def_data", {8'h0, if_def.data_o}, {8'h0, e.data});
                check("def_cycle", cyc, e.cyc);
            end
        end
        if (if_rnd.data_valid_o === 1'b1) begin
            if (q_rnd.size() == 0) check("rnd_unexpected_pulse", 1, 0);
            else begin
                e = q_rnd.pop_front();
                check("rnd_data", {8'h0, if_rnd.data_o}, {8'h0, e.data});
                check("rnd_cycle", cyc, e.cyc);
            end
        end
        if (if_pt.data_valid_o === 1'b1) begin
            if (q_pt.size() == 0) check("pt_unexpected_pulse", 1, 0);
            else begin
                e = q_pt.pop_front();
                check("pt_data", {8'h0, if_pt.data_o}, {8'h0, e.data});
                check("pt_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        model_clear();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_data_def", {8'h0, if_def.data_o}, 0);
        check("reset_valid_def", {31'h0, if_def.data_valid_o}, 0);
        check("reset_fill_def", {29'h0, if_def.fill_o}, 0);
        check("reset_data_pt", {8'h0, if_pt.data_o}, 0);

        // Defaults, non-consecutive valids.
        drive(100, 4095, 1, 0); idle(1);
        drive(200, 0, 1, 0);    idle(2);
        drive(300, 4095, 1, 0); idle(1);
        check("fill_after_3", {29'h0, if_def.fill_o}, 3);
        drive(400, 0, 1, 0);
        idle(1);
        check("avg_250_2047", {8'h0, if_def.data_o}, {8'h0, 12'd2047, 12'd250});
        idle(2);

        // Full-scale back-to-back, both rounding modes.
        for (int i = 0; i < 12; i++) drive(4095, 4095, 1, 0);
        idle(2);
        check("max_def", {8'h0, if_def.data_o}, {8'h0, 24'hffffff});
        check("max_rnd", {8'h0, if_rnd.data_o}, {8'h0, 24'hffffff});

        // Rounding: sum 7 on ch0, sum 5 on ch1.
        drive(1, 1, 1, 0); drive(2, 1, 1, 0); drive(2, 1, 1, 0); drive(2, 2, 1, 0);
        idle(1);
        check("round0_sum7_sum5", {8'h0, if_def.data_o}, {8'h0, 12'd1, 12'd1});
        check("round1_sum7_sum5", {8'h0, if_rnd.data_o}, {8'h0, 12'd1, 12'd2});
        idle(1);

        // Flush mid-block, then a clean block.
        drive(1000, 1000, 1, 0); drive(1000, 1000, 1, 0);
        drive(0, 0, 0, 1);
        idle(1);
        check("fill_after_flush", {29'h0, if_def.fill_o}, 0);
        check("data_held_on_flush", {8'h0, if_def.data_o}, {8'h0, 12'd1, 12'd1});
        for (int i = 0; i < 4; i++) drive(8, 8, 1, 0);
        idle(2);

        // Flush coincident with a valid drops that sample.
        drive(1, 1, 1, 0); drive(999, 999, 1, 1);
        for (int i = 0; i < 4; i++) drive(3, 40, 1, 0);
        idle(1);
        check("flush_coincident", {8'h0, if_def.data_o}, {8'h0, 12'd40, 12'd3});
        idle(1);

        // Reset after 3 of 4 samples.
        drive(50, 60, 1, 0); drive(50, 60, 1, 0); drive(50, 60, 1, 0);
        @(posedge clk);
        #1;
        vin = 1'b0;
        rst = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_data", {8'h0, if_def.data_o}, 0);
        check("rst_mid_fill", {29'h0, if_def.fill_o}, 0);
        check("rst_mid_pt_data", {8'h0, if_pt.data_o}, 0);
        for (int i = 0; i < 4; i++) drive(10 * (i + 1), 7, 1, 0);
        idle(2);

        // Pass-through: 5, 6, 7 back-to-back; partial block then flushed.
        drive(5, 5, 1, 0); drive(6, 6, 1, 0); drive(7, 7, 1, 0);
        idle(1);
        check("pt_last", {8'h0, if_pt.data_o}, {8'h0, 12'd7, 12'd7});
        check("pt_fill", {29'h0, if_pt.fill_o}, 0);
        drive(0, 0, 0, 1);
        idle(4);

        check("def_queue_drained", q_def.size(), 0);
        check("rnd_queue_drained", q_rnd.size(), 0);
        check("pt_queue_drained", q_pt.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
